// File: rtl/bcd_stopwatch_counter_pkg.sv
// rtl/bcd_stopwatch_counter_pkg.sv - shared state encodings and BCD limits
package bcd_stopwatch_counter_pkg;

    typedef enum logic {
        ST_PAUSED  = 1'b0,
        ST_RUNNING = 1'b1
    } state_e;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

endpackage

// File: rtl/bcd_stopwatch_counter_key_edge.sv
// rtl/bcd_stopwatch_counter_key_edge.sv - key synchronizer chain with falling-edge press detect
module bcd_stopwatch_counter_key_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    import bcd_stopwatch_counter_pkg::*;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic                   hist_q, hist_d;

    // History only arms once a released level has travelled the whole chain,
    // so a key held down through reset must be let go before it can press.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], key_n};
        vld_d  = {vld_q[SYNC_STAGES-2:0], 1'b1};
        hist_d = vld_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1];
        press  = ~sync_q[SYNC_STAGES-1] & hist_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            vld_q  <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            vld_q  <= vld_d;
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/bcd_stopwatch_counter.sv
// rtl/bcd_stopwatch_counter.sv - two-digit BCD up/down stopwatch with run/step/clear keys
module bcd_stopwatch_counter #(
    parameter int TICK_DIV    = 50000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_run_n,
    input  logic       key_step_n,
    input  logic       key_clr_n,
    input  logic       up_dn,
    output logic [3:0] q_ones,
    output logic [3:0] q_tens,
    output logic       running,
    output logic       wrap
);
    import bcd_stopwatch_counter_pkg::*;

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    ones_q, ones_d, tens_q, tens_d;
    logic          wrap_q, wrap_d;
    logic          run_ev, step_ev, clr_ev;
    logic          tick, advance;

    bcd_stopwatch_counter_key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_run (
        .clk(clk), .rst_n(rst_n), .key_n(key_run_n), .press(run_ev)
    );
    bcd_stopwatch_counter_key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_step (
        .clk(clk), .rst_n(rst_n), .key_n(key_step_n), .press(step_ev)
    );
    bcd_stopwatch_counter_key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_clr (
        .clk(clk), .rst_n(rst_n), .key_n(key_clr_n), .press(clr_ev)
    );

    always_comb begin
        state_d = state_q;
        presc_d = '0;
        tick    = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_PAUSED: begin
                advance = step_ev;
                if (run_ev) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                tick    = (presc_q == TICK_LAST);
                advance = tick;
                if (run_ev)     state_d = ST_PAUSED;
                else if (!tick) presc_d = presc_q + 1'b1;
            end
            default: state_d = ST_PAUSED;
        endcase
    end

    // Clear outranks an advance on the same edge but leaves state/prescaler alone.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        wrap_d = 1'b0;
        if (clr_ev) begin
            ones_d = BCD_ZERO;
            tens_d = BCD_ZERO;
        end else if (advance) begin
            if (up_dn) begin
                if (ones_q == BCD_MAX) begin
                    ones_d = BCD_ZERO;
                    if (tens_q == BCD_MAX) begin
                        tens_d = BCD_ZERO;
                        wrap_d = 1'b1;
                    end else begin
                        tens_d = tens_q + 4'd1;
                    end
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                if (ones_q == BCD_ZERO) begin
                    ones_d = BCD_MAX;
                    if (tens_q == BCD_ZERO) begin
                        tens_d = BCD_MAX;
                        wrap_d = 1'b1;
                    end else begin
                        tens_d = tens_q - 4'd1;
                    end
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_PAUSED;
            presc_q <= '0;
            ones_q  <= BCD_ZERO;
            tens_q  <= BCD_ZERO;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q_ones  = ones_q;
    assign q_tens  = tens_q;
    assign running = (state_q == ST_RUNNING);
    assign wrap    = wrap_q;

endmodule
